// File: rtl/cnn_pkg.sv
// Shared sizing helpers and state encoding for the CNN feature-map pipeline
// (activation, pooling and serializer stages).
package cnn_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  function automatic int elem_width(input int bitwidth);
    return 2 * bitwidth;
  endfunction

  function automatic int frame_total(input int h, input int w, input int c);
    return h * w * c;
  endfunction

  function automatic int beat_count(input int total, input int pf);
    return (total + pf - 1) / pf;
  endfunction

  // A single-beat frame still needs a 1-bit beat index.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fmap_beat_select.sv
// Lane multiplexer: picks beat beat_idx out of a captured frame and flags
// which lanes carry real elements (tail lanes of the last beat are padding).
module fmap_beat_select #(
  parameter int EW    = 32,
  parameter int TOTAL = 288,
  parameter int PF    = 4,
  parameter int BEATS = 72,
  parameter int IDXW  = 7
) (
  input  logic [EW*TOTAL-1:0] frame,
  input  logic [IDXW-1:0]     beat_idx,
  output logic [EW*PF-1:0]    beat_data,
  output logic [PF-1:0]       beat_keep
);

  localparam int SLOTS = BEATS * PF;

  logic [SLOTS*EW-1:0] padded;
  logic [SLOTS-1:0]    keep_flat;
  logic [PF*EW-1:0]    beat_arr [BEATS];
  logic [PF-1:0]       keep_arr [BEATS];

  // Zero-extend the frame so every beat is a full PF-lane slice.
  if (SLOTS > TOTAL) begin : g_pad
    assign padded = {{((SLOTS - TOTAL) * EW){1'b0}}, frame};
  end else begin : g_nopad
    assign padded = frame;
  end

  for (genvar j = 0; j < SLOTS; j++) begin : g_keep
    assign keep_flat[j] = (j < TOTAL) ? 1'b1 : 1'b0;
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign beat_arr[b] = padded[b*PF*EW +: PF*EW];
    assign keep_arr[b] = keep_flat[b*PF +: PF];
  end

  assign beat_data = beat_arr[beat_idx];
  assign beat_keep = keep_arr[beat_idx];

endmodule

// File: rtl/fmap_serializer.sv
// Captures a whole feature map on a single-cycle pulse and streams it out as
// PF-element beats with valid/ready handshaking, keep mask and last flag.
module fmap_serializer
  import cnn_pkg::*;
#(
  parameter int BITWIDTH        = 16,
  parameter int DATA_WIDTH      = 6,
  parameter int DATA_HEIGHT     = 6,
  parameter int DATA_CHANNELS   = 8,
  parameter int PARALLEL_FACTOR = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clken,
  input  logic in_valid,
  input  logic [elem_width(BITWIDTH)*frame_total(DATA_HEIGHT, DATA_WIDTH, DATA_CHANNELS)-1:0] data_in,
  output logic in_ready,
  output logic m_valid,
  input  logic m_ready,
  output logic [elem_width(BITWIDTH)*PARALLEL_FACTOR-1:0] m_data,
  output logic [PARALLEL_FACTOR-1:0] m_keep,
  output logic m_last,
  output logic overrun
);

  localparam int EW    = elem_width(BITWIDTH);
  localparam int TOTAL = frame_total(DATA_HEIGHT, DATA_WIDTH, DATA_CHANNELS);
  localparam int PF    = PARALLEL_FACTOR;
  localparam int BEATS = beat_count(TOTAL, PF);
  localparam int IDXW  = idx_width(BEATS);

  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

  ser_state_e          state_q, state_d;
  logic [IDXW-1:0]     beat_idx_q, beat_idx_d;
  logic [EW*TOTAL-1:0] frame_q, frame_d;
  logic                overrun_q, overrun_d;

  logic [EW*PF-1:0]    beat_data;
  logic [PF-1:0]       beat_keep;
  logic                last_beat;

  assign last_beat = (beat_idx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    frame_d    = frame_q;
    overrun_d  = overrun_q;
    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            frame_d    = data_in;
            beat_idx_d = '0;
            state_d    = ST_STREAM;
          end
        end
        ST_STREAM: begin
          // A frame offered while streaming is dropped; only the flag records it.
          if (in_valid) begin
            overrun_d = 1'b1;
          end
          if (m_ready) begin
            if (last_beat) begin
              state_d    = ST_IDLE;
              beat_idx_d = '0;
            end else begin
              beat_idx_d = beat_idx_q + IDX_ONE;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          beat_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_idx_q <= '0;
      frame_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      frame_q    <= frame_d;
      overrun_q  <= overrun_d;
    end
  end

  fmap_beat_select #(
    .EW    (EW),
    .TOTAL (TOTAL),
    .PF    (PF),
    .BEATS (BEATS),
    .IDXW  (IDXW)
  ) u_beat_select (
    .frame     (frame_q),
    .beat_idx  (beat_idx_q),
    .beat_data (beat_data),
    .beat_keep (beat_keep)
  );

  // Payload is forced to zero outside STREAM so idle/reset outputs are clean.
  assign in_ready = (state_q == ST_IDLE);
  assign m_valid  = (state_q == ST_STREAM);
  assign m_data   = m_valid ? beat_data : '0;
  assign m_keep   = m_valid ? beat_keep : '0;
  assign m_last   = m_valid & last_beat;
  assign overrun  = overrun_q;

endmodule

// File: doc/fmap_serializer.md
FMAP_SERIALIZER -- requirements
Module: fmap_serializer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16: base width; each element is 2*BITWIDTH bits (EW).
REQ-002 SHALL have parameter DATA_WIDTH, default 6: feature-map columns.
REQ-003 SHALL have parameter DATA_HEIGHT, default 6: feature-map rows.
REQ-004 SHALL have parameter DATA_CHANNELS, default 8: feature-map channels.
REQ-005 SHALL have parameter PARALLEL_FACTOR (PF), default 4: elements per output beat.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port clken  input  1  clock enable; all state advances only when high.
REQ-009 SHALL have port in_valid  input  1  single-cycle frame-valid pulse from the activation stage.
REQ-010 SHALL have port data_in  input  EW*TOTAL  flattened frame, element j at bits [j*EW +: EW], TOTAL = H*W*C.
REQ-011 SHALL have port in_ready  output  1  high when a frame can be captured.
REQ-012 SHALL have port m_valid  output  1  output beat valid.
REQ-013 SHALL have port m_ready  input  1  downstream accepts beat.
REQ-014 SHALL have port m_data  output  EW*PF  beat payload, lane p at [p*EW +: EW].
REQ-015 SHALL have port m_keep  output  PF  per-lane valid mask.
REQ-016 SHALL have port m_last  output  1  final beat of frame.
REQ-017 SHALL have port overrun  output  1  sticky: a frame arrived while busy and was dropped.

Function
REQ-018 SHALL implement states IDLE and STREAM; BEATS = ceil(TOTAL/PF).
REQ-019 in_ready SHALL equal (state==IDLE), combinational from state only.
REQ-020 In IDLE with clken && in_valid: capture data_in into frame register, beat_idx <= 0, go to STREAM.
REQ-021 m_valid SHALL be high exactly while in STREAM; first beat visible the cycle after capture (latency 1).
REQ-022 Transfer SHALL be defined as clken && m_valid && m_ready; beat_idx increments by 1 per transfer.
REQ-023 Beat k lane p SHALL carry element k*PF+p; lanes with index >= TOTAL SHALL be zero with m_keep[p]=0, otherwise m_keep[p]=1.
REQ-024 m_last SHALL be high iff beat_idx == BEATS-1 while m_valid.
REQ-025 m_data, m_keep, m_last SHALL remain stable while m_valid && !m_ready (or clken low).
REQ-026 Transfer with m_last: return to IDLE; in_ready high the next cycle.
REQ-027 in_valid in STREAM: frame dropped, captured frame and beat sequence unaffected, overrun <= 1 (sticky).
REQ-028 clken low: all registers hold, including state, beat_idx, overrun.
REQ-029 beat_idx width SHALL be clog2(BEATS) (min 1); no wrap within a frame.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, beat_idx=0, frame register=0, overrun=0; m_valid=0, m_last=0, m_keep=0, m_data=0, in_ready=1.
REQ-031 Reset mid-frame SHALL abandon the frame; no beat emitted after release until a new in_valid.

Structure
REQ-032 EW, TOTAL, BEATS and state encodings SHALL live in shared package cnn_pkg, reused by activation/pooling stages.
REQ-033 Lane mux plus keep generation SHALL be sub-module fmap_beat_select (frame, beat_idx -> m_data, m_keep); the FSM remains in fmap_serializer.

Verification
REQ-034 Defaults, data_in element j = j, m_ready=1: 72 beats, beat k lanes = {4k..4k+3}, m_keep=4'hF, m_last only on beat 71, in_ready high the cycle after.
REQ-035 H=2,W=2,C=1,PF=3: beat0 lanes {0,1,2} keep=3'b111; beat1 lane0=3, lanes1-2 = 0, keep=3'b001, m_last=1.
REQ-036 m_ready toggled pseudo-randomly: payload and m_valid held during stalls; exactly 72 transfers with correct order.
REQ-037 Second in_valid at beat 10 with a different pattern: overrun=1 and stays 1; the stream still delivers the first frame intact.
REQ-038 rst_n asserted at beat 30: outputs reach reset values immediately; after release no m_valid until the next in_valid, then a full 72-beat frame.
REQ-039 clken low for 5 cycles mid-stream with m_ready=1: no beat_idx advance, outputs stable, and the sequence resumes at the same beat.
